// File: rtl/morse_pkg.sv
// Shared Morse definitions for the transmitter and the decoder path.
// Codes are packed as four 2-bit symbols, with the first symbol in [7:6].
package morse_pkg;

   localparam logic [1:0] SYM_EMPTY = 2'b00;
   localparam logic [1:0] SYM_DOT   = 2'b01;
   localparam logic [1:0] SYM_DASH  = 2'b10;
   localparam logic [1:0] SYM_RSVD  = 2'b11;

   localparam int DEFAULT_UNIT_TICKS = 12_500_000;

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      SPACE,
      GAP
   } morse_state_t;

   // Returns symbol idx of a packed code; idx 0 is the first symbol.
   function automatic logic [1:0] sym_at(input logic [7:0] code, input logic [1:0] idx);
      logic [7:0] shifted;
      shifted = code << {idx, 1'b0};
      return shifted[7:6];
   endfunction

endpackage

// File: rtl/morse_encoder_rom.sv
// ASCII to packed Morse lookup, the inverse of the decoder mapping.
// Lowercase is folded to uppercase; anything outside A-Z clears code_valid.
module morse_encoder_rom
   import morse_pkg::*;
(
   input  logic [7:0] ascii,
   output logic [7:0] code,
   output logic       code_valid
);

   logic [7:0] upper;

   always_comb begin
      upper      = ascii;
      code       = 8'h00;
      code_valid = 1'b1;
      if (ascii >= 8'h61 && ascii <= 8'h7A) begin
         upper = ascii - 8'h20;
      end
      case (upper)
         "A": code = 8'h60;
         "B": code = 8'h95;
         "C": code = 8'h99;
         "D": code = 8'h94;
         "E": code = 8'h40;
         "F": code = 8'h59;
         "G": code = 8'hA4;
         "H": code = 8'h55;
         "I": code = 8'h50;
         "J": code = 8'h6A;
         "K": code = 8'h98;
         "L": code = 8'h65;
         "M": code = 8'hA0;
         "N": code = 8'h90;
         "O": code = 8'hA8;
         "P": code = 8'h69;
         "Q": code = 8'hA6;
         "R": code = 8'h64;
         "S": code = 8'h54;
         "T": code = 8'h80;
         "U": code = 8'h58;
         "V": code = 8'h56;
         "W": code = 8'h68;
         "X": code = 8'h96;
         "Y": code = 8'h9A;
         "Z": code = 8'hA5;
         default: code_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/morse_transmitter.sv
// Keys one ASCII letter as Morse on tone: dot 1 unit, dash 3 units, 1 unit between symbols, 3-unit trailing gap.
// Handshake: a letter is taken on a rising edge where letter_valid && ready; ready is high only in IDLE.
module morse_transmitter
   import morse_pkg::*;
#(
   parameter int UNIT_TICKS = DEFAULT_UNIT_TICKS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       letter_valid,
   input  logic [7:0] letter,
   output logic       ready,
   output logic       tone,
   output logic [7:0] MorsePacked,
   output logic       done,
   output logic       error
);

   localparam int CNT_W = (3 * UNIT_TICKS > 1) ? $clog2(3 * UNIT_TICKS) : 1;
   localparam logic [CNT_W-1:0] UNIT_LOAD = CNT_W'(UNIT_TICKS - 1);
   localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(3 * UNIT_TICKS - 1);

   morse_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       code_q, code_d;
   logic             tone_q, tone_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic [7:0]       rom_code;
   logic             rom_valid;
   logic [1:0]       next_sym;

   morse_encoder_rom u_rom (
      .ascii      (letter),
      .code       (rom_code),
      .code_valid (rom_valid)
   );

   function automatic logic [CNT_W-1:0] mark_load(input logic [1:0] sym);
      return (sym == SYM_DASH) ? LONG_LOAD : UNIT_LOAD;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      code_d   = code_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      next_sym = (idx_q == 2'd3) ? SYM_EMPTY : sym_at(code_q, idx_q + 2'd1);
      case (state_q)
         IDLE: begin
            if (letter_valid) begin
               if (rom_valid) begin
                  code_d  = rom_code;
                  idx_d   = 2'd0;
                  cnt_d   = mark_load(rom_code[7:6]);
                  state_d = MARK;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         MARK: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (next_sym == SYM_DOT || next_sym == SYM_DASH) begin
               cnt_d   = UNIT_LOAD;
               state_d = SPACE;
            end else begin
               // Empty or reserved next symbol both terminate the letter.
               cnt_d   = LONG_LOAD;
               state_d = GAP;
            end
         end
         SPACE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               idx_d   = idx_q + 2'd1;
               cnt_d   = mark_load(next_sym);
               state_d = MARK;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      tone_d = (state_d == MARK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         code_q  <= 8'h00;
         tone_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         tone_q  <= tone_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   assign ready       = (state_q == IDLE);
   assign tone        = tone_q;
   assign MorsePacked = code_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_morse_transmitter.sv
// Self-checking bench for morse_transmitter at UNIT_TICKS = 2.
// Expected tone per cycle is generated from a dot/dash table and compared each cycle.
module tb_morse_transmitter;

   localparam int UNIT = 2;
   localparam int W    = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       letter_valid;
   logic [7:0] letter;
   logic       ready;
   logic       tone;
   logic [7:0] morse_packed;
   logic       done;
   logic       error;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] exp_q[$];

   string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                            ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                            "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

   morse_transmitter #(.UNIT_TICKS(UNIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .letter_valid (letter_valid),
      .letter       (letter),
      .ready        (ready),
      .tone         (tone),
      .MorsePacked  (morse_packed),
      .done         (done),
      .error        (error)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pack_code(input string m);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < m.len(); i++) begin
         c[7 - 2 * i -: 2] = (m[i] == "-") ? 2'b10 : 2'b01;
      end
      return c;
   endfunction

   task automatic push_waveform(input string m);
      for (int i = 0; i < m.len(); i++) begin
         repeat ((m[i] == "-") ? 3 * UNIT : UNIT) exp_q.push_back(1'b1);
         if (i < m.len() - 1) repeat (UNIT) exp_q.push_back(1'b0);
      end
      repeat (3 * UNIT) exp_q.push_back(1'b0);
   endtask

   // Called just after the accepting edge; consumes exp_q then checks the done cycle.
   task automatic drain_and_check(input string name, input logic [7:0] exp_code);
      logic [W-1:0] e;
      int n;
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if ({tone, ready, done, error} !== {e, 3'b000}) begin
            miscompares++;
            $display("FAIL %s cycle %0d: tone/ready/done/error=%b expected %b",
                     name, n, {tone, ready, done, error}, {e, 3'b000});
         end
         if (n == 0) begin
            vectors++;
            if (morse_packed !== exp_code) begin
               miscompares++;
               $display("FAIL %s packed: got %h expected %h", name, morse_packed, exp_code);
            end
         end
         n++;
      end
      @(negedge clk);
      vectors++;
      if ({tone, ready, done, error} !== 4'b0110) begin
         miscompares++;
         $display("FAIL %s done_cycle: tone/ready/done/error=%b expected 0110",
                  name, {tone, ready, done, error});
      end
   endtask

   task automatic send_letter(input logic [7:0] ch, input string m, input logic [7:0] exp_code);
      @(negedge clk);
      letter_valid = 1'b1;
      letter       = ch;
      push_waveform(m);
      @(posedge clk);
      #1 letter_valid = 1'b0;
      drain_and_check($sformatf("letter_%c", ch), exp_code);
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      letter_valid = 1'b0;
      letter       = 8'h00;
      @(negedge clk);
      vectors++;
      if ({tone, ready, done, error, morse_packed} !== {4'b0100, 8'h00}) begin
         miscompares++;
         $display("FAIL reset: tone/ready/done/error/packed=%b/%h expected 0100/00",
                  {tone, ready, done, error}, morse_packed);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_spec_letters();
      send_letter(8'h45, ".", 8'h40);
      send_letter(8'h61, ".-", 8'h60);
      send_letter(8'h51, "--.-", 8'hA6);
   endtask

   task automatic test_unsupported();
      logic [7:0] bad[5];
      bad = '{8'h35, 8'h40, 8'h5B, 8'h60, 8'h7B};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         letter_valid = 1'b1;
         letter       = bad[i];
         @(posedge clk);
         #1 letter_valid = 1'b0;
         @(negedge clk);
         vectors++;
         if ({tone, ready, done, error, morse_packed} !== {4'b0101, 8'hA6}) begin
            miscompares++;
            $display("FAIL unsupported_%h: tone/ready/done/error/packed=%b/%h expected 0101/a6",
                     bad[i], {tone, ready, done, error}, morse_packed);
         end
         @(negedge clk);
         vectors++;
         if ({tone, ready, done, error} !== 4'b0100) begin
            miscompares++;
            $display("FAIL unsupported_%h_after: tone/ready/done/error=%b expected 0100",
                     bad[i], {tone, ready, done, error});
         end
      end
   endtask

   task automatic test_boundaries();
      send_letter(8'h5A, "--..", 8'hA5);
      send_letter(8'h7A, "--..", 8'hA5);
      send_letter(8'h41, ".-", 8'h60);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      letter_valid = 1'b1;
      letter       = 8'h54;
      push_waveform("-");
      @(posedge clk);
      #1 letter = 8'h45;
      drain_and_check("bb_T", 8'h80);
      vectors++;
      if (morse_packed !== 8'h80) begin
         miscompares++;
         $display("FAIL bb_T_hold: packed=%h expected 80", morse_packed);
      end
      push_waveform(".");
      @(posedge clk);
      #1 letter_valid = 1'b0;
      drain_and_check("bb_E", 8'h40);
   endtask

   task automatic test_random();
      int idx;
      logic [7:0] ch;
      for (int k = 0; k < 6; k++) begin
         idx = $urandom_range(0, 25);
         ch  = 8'(8'h41 + idx);
         if ($urandom_range(0, 1) == 1) ch = ch + 8'h20;
         send_letter(ch, morse_tab[idx], pack_code(morse_tab[idx]));
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      letter_valid = 1'b1;
      letter       = 8'h54;
      @(posedge clk);
      #1 letter_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({tone, ready, done, error, morse_packed} !== {4'b0100, 8'h00}) begin
         miscompares++;
         $display("FAIL mid_reset: tone/ready/done/error/packed=%b/%h expected 0100/00",
                  {tone, ready, done, error}, morse_packed);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         vectors++;
         if ({tone, ready, done, error} !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_reset_quiet cycle %0d: tone/ready/done/error=%b expected 0100",
                     c, {tone, ready, done, error});
         end
      end
      // Release reset and present a letter together: it must go on the first edge.
      #2 rst = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      letter_valid = 1'b1;
      letter       = 8'h45;
      push_waveform(".");
      @(posedge clk);
      #1 letter_valid = 1'b0;
      drain_and_check("post_reset_E", 8'h40);
   endtask

   initial begin
      test_reset();
      test_spec_letters();
      test_unsupported();
      test_boundaries();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
